maze_pixel_renderer: RTL and testbench

Renders the maze scene into 12-bit RGB. It sits directly downstream of the VGA timing generator and consumes its pixel position and sync signals. A two-stage pipeline looks up a 20×15 tile map and overlays the player marker. Sync outputs are delayed by the same latency, so colour and sync reach the DAC pins aligned.

---
 rtl/maze_pkg.sv | 52 +++++
 rtl/maze_tile_ram.sv | 23 ++
 rtl/maze_pixel_renderer.sv | 116 +++++++++++
 tb/tb_maze_pixel_renderer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants and types for the maze pixel renderer.
// The MAZE_GRID_LINES_EN build option is consumed in maze_pixel_renderer.sv.
package maze_pkg;

  localparam int TILE_LOG2 = 5;
  localparam int COLS      = 20;
  localparam int ROWS      = 15;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int MAP_DEPTH = COLS * ROWS;
  localparam int ADDR_W    = 9;
  localparam int POS_W     = 11;
  localparam int TILE_W    = POS_W - TILE_LOG2;
  localparam int STAGES    = 2;

  // Player marker is drawn only inside this inset of its tile.
  localparam logic [TILE_LOG2-1:0] INSET_LO = TILE_LOG2'(4);
  localparam logic [TILE_LOG2-1:0] INSET_HI = TILE_LOG2'(27);

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_WALL  = 2'd1,
    TILE_GOAL  = 2'd2,
    TILE_RSVD  = 2'd3
  } tile_e;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COLOR_BLACK  = 12'h000;
  localparam rgb_t COLOR_WALL   = 12'h00F;
  localparam rgb_t COLOR_GOAL   = 12'h0F0;
  localparam rgb_t COLOR_PLAYER = 12'hF00;
  localparam rgb_t COLOR_GRID   = 12'h333;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [TILE_LOG2-1:0] off_x;
    logic [TILE_LOG2-1:0] off_y;
    logic                 player;
  } s1_t;

  typedef struct packed {
    logic [TILE_LOG2-1:0] off_x;
    logic [TILE_LOG2-1:0] off_y;
    logic                 player;
  } s2_t;

  function automatic logic in_inset(input logic [TILE_LOG2-1:0] off);
    return (off >= INSET_LO) && (off <= INSET_HI);
  endfunction

endpackage

// File: rtl/maze_tile_ram.sv
// 300x2 tile map: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module maze_tile_ram
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [1:0]        rdata
);

  logic [1:0] mem [MAP_DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < ADDR_W'(MAP_DEPTH)))
      mem[waddr] <= wdata;
    // Off-map reads only happen for blanked pixels; return empty.
    rdata <= (raddr < ADDR_W'(MAP_DEPTH)) ? mem[raddr] : TILE_EMPTY;
  end

endmodule

// File: rtl/maze_pixel_renderer.sv
// Two-stage maze renderer: tile lookup plus player overlay, syncs delayed to match.
// Build option MAZE_GRID_LINES_EN draws grey grid lines on empty tiles.
module maze_pixel_renderer
  import maze_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [POS_W-1:0] i_HPos,
  input  logic [POS_W-1:0] i_VPos,
  input  logic             i_HSync,
  input  logic             i_VSync,
  input  logic             i_MapWe,
  input  logic [8:0]       i_MapAddr,
  input  logic [1:0]       i_MapData,
  input  logic [4:0]       i_PlayerX,
  input  logic [3:0]       i_PlayerY,
  output logic [3:0]       o_Red,
  output logic [3:0]       o_Green,
  output logic [3:0]       o_Blue,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_FrameDone
);

  logic [TILE_W-1:0] col_in, row_in;
  logic              vis_in, hit_in, latch;
  s1_t               s1_in, s1;
  s2_t               s2;
  logic [STAGES:1]   vld_pipe, hs_pipe, vs_pipe;
  logic [4:0]        player_x;
  logic [3:0]        player_y;
  logic              frame_done;
  logic [1:0]        tile_code;
  rgb_t              rgb;

  assign col_in = i_HPos[POS_W-1:TILE_LOG2];
  assign row_in = i_VPos[POS_W-1:TILE_LOG2];
  assign vis_in = (i_HPos < POS_W'(H_VISIBLE)) && (i_VPos < POS_W'(V_VISIBLE));
  assign latch  = (i_VPos == POS_W'(V_VISIBLE)) && (i_HPos == '0);

  // An off-map latched player can never match, so it is simply not drawn.
  assign hit_in = (col_in == TILE_W'(player_x)) && (row_in == TILE_W'(player_y)) &&
                  (player_x < 5'(COLS)) && (player_y < 4'(ROWS));

  always_comb begin
    s1_in        = '0;
    s1_in.addr   = ADDR_W'(row_in) * ADDR_W'(COLS) + ADDR_W'(col_in);
    s1_in.off_x  = i_HPos[TILE_LOG2-1:0];
    s1_in.off_y  = i_VPos[TILE_LOG2-1:0];
    s1_in.player = hit_in;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vld_pipe   <= '0;
      hs_pipe    <= '1;
      vs_pipe    <= '1;
      s1         <= '0;
      s2         <= '0;
      player_x   <= '0;
      player_y   <= '0;
      frame_done <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], vis_in};
      hs_pipe    <= {hs_pipe[STAGES-1:1], i_HSync};
      vs_pipe    <= {vs_pipe[STAGES-1:1], i_VSync};
      s1         <= s1_in;
      s2.off_x   <= s1.off_x;
      s2.off_y   <= s1.off_y;
      s2.player  <= s1.player;
      frame_done <= latch;
      // Latch in vertical blanking so the marker never tears mid-frame.
      if (latch) begin
        player_x <= i_PlayerX;
        player_y <= i_PlayerY;
      end
    end
  end

  maze_tile_ram u_ram (
    .clk   (i_Clk),
    .we    (i_MapWe),
    .waddr (i_MapAddr),
    .wdata (i_MapData),
    .raddr (s1.addr),
    .rdata (tile_code)
  );

  always_comb begin
    rgb = COLOR_BLACK;
    if (vld_pipe[STAGES]) begin
      if (s2.player && in_inset(s2.off_x) && in_inset(s2.off_y)) begin
        rgb = COLOR_PLAYER;
      end else begin
        case (tile_e'(tile_code))
          TILE_WALL: rgb = COLOR_WALL;
          TILE_GOAL: rgb = COLOR_GOAL;
          default: begin
`ifdef MAZE_GRID_LINES_EN
            if ((s2.off_x == '0) || (s2.off_y == '0))
              rgb = COLOR_GRID;
`endif
          end
        endcase
      end
    end
  end

  assign o_Red       = rgb[11:8];
  assign o_Green     = rgb[7:4];
  assign o_Blue      = rgb[3:0];
  assign o_HSync     = hs_pipe[STAGES];
  assign o_VSync     = vs_pipe[STAGES];
  assign o_FrameDone = frame_done;

endmodule

// File: tb/tb_maze_pixel_renderer.sv
// Directed and randomized bench for maze_pixel_renderer against a pixel-level model.
// A pixel's map read happens the cycle after it is presented, so a write presented then is not seen.
module tb_maze_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hpos, vpos;
  logic        hs, vs, we;
  logic [8:0]  addr;
  logic [1:0]  data;
  logic [4:0]  px;
  logic [3:0]  py;
  logic [3:0]  red, green, blue;
  logic        hs_o, vs_o, fd_o;

  always #5 clk = ~clk;

  maze_pixel_renderer dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_HPos      (hpos),
    .i_VPos      (vpos),
    .i_HSync     (hs),
    .i_VSync     (vs),
    .i_MapWe     (we),
    .i_MapAddr   (addr),
    .i_MapData   (data),
    .i_PlayerX   (px),
    .i_PlayerY   (py),
    .o_Red       (red),
    .o_Green     (green),
    .o_Blue      (blue),
    .o_HSync     (hs_o),
    .o_VSync     (vs_o),
    .o_FrameDone (fd_o)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   map [300];
  int   pl_x, pl_y;
  int   in_px, in_py;
  bit   fd_exp, started;
  int   n_assert, n_fail;

  function automatic logic [11:0] ref_color(int h, int v);
    int col, row, ox, oy, code;
    if (h >= 640 || v >= 480) return 12'h000;
    col = h / 32; row = v / 32; ox = h % 32; oy = v % 32;
    if (pl_x < 20 && pl_y < 15 && col == pl_x && row == pl_y &&
        ox >= 4 && ox <= 27 && oy >= 4 && oy <= 27) return 12'hF00;
    code = map[row * 20 + col];
    if (code == 1) return 12'h00F;
    if (code == 2) return 12'h0F0;
`ifdef MAZE_GRID_LINES_EN
    if (ox == 0 || oy == 0) return 12'h333;
`endif
    return 12'h000;
  endfunction

  task automatic check();
    exp_t e;
    logic [11:0] rgb;
    if (started) begin
      n_assert++;
      assert (fd_o === fd_exp) else begin
        n_fail++; $error("FAIL frame_done got %0b exp %0b", fd_o, fd_exp);
      end
    end
    if (q.size() >= 2) begin
      e = q.pop_front();
      rgb = {red, green, blue};
      n_assert++;
      assert (rgb === e.rgb) else begin
        n_fail++; $error("FAIL %s rgb got %h exp %h", e.tag, rgb, e.rgb);
      end
      n_assert++;
      assert (hs_o === e.hs) else begin
        n_fail++; $error("FAIL %s hsync got %0b exp %0b", e.tag, hs_o, e.hs);
      end
      n_assert++;
      assert (vs_o === e.vs) else begin
        n_fail++; $error("FAIL %s vsync got %0b exp %0b", e.tag, vs_o, e.vs);
      end
    end
  endtask

  task automatic step(input string tag, input int h, input int v, input bit hsv, input bit vsv,
                      input bit r, input bit w, input int a, input int d);
    exp_t e;
    @(negedge clk);
    check();
    rst = r; hpos = 11'(h); vpos = 11'(v); hs = hsv; vs = vsv;
    we = w; addr = 9'(a); data = 2'(d); px = 5'(in_px); py = 4'(in_py);
    if (w && a < 300) map[a] = d;
    e.tag = tag;
    if (r) begin
      // Reset blanks the older in-flight pixel as well as this one.
      if (q.size() > 0) begin
        q[q.size()-1].rgb = 12'h000; q[q.size()-1].hs = 1'b1; q[q.size()-1].vs = 1'b1;
      end
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
      pl_x = 0; pl_y = 0; fd_exp = 1'b0;
    end else begin
      e.rgb = ref_color(h, v); e.hs = hsv; e.vs = vsv;
      fd_exp = (v == 480 && h == 0);
      if (fd_exp) begin pl_x = in_px; pl_y = in_py; end
    end
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic pix(input string tag, input int h, input int v);
    step(tag, h, v, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    step("write", 700, 500, 1'b1, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; started = 1'b0; fd_exp = 1'b0;
    in_px = 0; in_py = 0; pl_x = 0; pl_y = 0;
    rst = 1'b1; hpos = '0; vpos = '0; hs = 1'b1; vs = 1'b1;
    we = 1'b0; addr = '0; data = '0; px = '0; py = '0;

    for (int i = 0; i < 4; i++) step("reset", 40 + i, 40, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step("release", 700, 500, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    step("hs_fall", 700, 500, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    step("vs_fall", 700, 500, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // All walls, then blanked positions must stay black.
    for (int a = 0; a < 300; a++) wr(a, 1);
    for (int v = 0; v < 6; v++) pix("hblank_wall", 640 + 12 * v, 31 * v);
    pix("vblank_wall", 100, 500);
    pix("wall_vis", 300, 300);

    for (int a = 0; a < 300; a++) wr(a, int'($urandom_range(0, 3)));
    wr(21, 1); wr(22, 0); wr(1, 0); wr(43, 0);
    pix("wall21", 40, 40);
    pix("empty22_edge", 64, 40);
    pix("empty22", 65, 40);
    pix("grid_col", 32, 10);
    pix("grid_none", 33, 10);
    pix("player_rst00", 10, 10);

    in_px = 3; in_py = 2;
    pix("latch", 0, 480);
    pix("player", 100, 80);
    pix("player_edge", 97, 80);
    pix("player_hi", 123, 107);
    pix("player_out", 124, 80);

    in_px = 5; in_py = 5;
    pix("no_tear_old", 100, 200);
    pix("no_tear_old2", 100, 80);
    pix("no_tear_new", 170, 170);
    pix("latch2", 0, 480);
    pix("moved_new", 170, 170);
    pix("moved_old", 100, 80);

    wr(0, 0);
    pix("coll_before", 5, 5);
    step("coll_write", 6, 5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2);
    pix("coll_after", 7, 5);
    step("addr300", 8, 5, 1'b1, 1'b1, 1'b0, 1'b1, 300, 1);
    pix("addr300_after", 9, 5);

    pix("pre_reset", 200, 200);
    step("mid_reset", 200, 200, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    step("mid_reset", 201, 200, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    pix("post_reset_player", 10, 10);
    pix("post_reset", 10, 200);

    for (int i = 0; i < 1500; i++) begin
      int h, v, a, d;
      bit w, hsv, vsv;
      if ($urandom_range(0, 39) == 0) begin
        h = 0; v = 480;
        in_px = int'($urandom_range(0, 21)); in_py = int'($urandom_range(0, 15));
      end else if ($urandom_range(0, 3) == 0 && pl_x < 20 && pl_y < 15) begin
        h = pl_x * 32 + int'($urandom_range(0, 31));
        v = pl_y * 32 + int'($urandom_range(0, 31));
      end else begin
        h = int'($urandom_range(0, 799)); v = int'($urandom_range(0, 524));
      end
      w = ($urandom_range(0, 3) == 0);
      a = int'($urandom_range(0, 319)); d = int'($urandom_range(0, 3));
      hsv = 1'($urandom_range(0, 1)); vsv = 1'($urandom_range(0, 1));
      step("random", h, v, hsv, vsv, 1'b0, w, a, d);
    end

    for (int i = 0; i < 3; i++) pix("drain", 700, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
